equiv_check_sequencer: RTL and testbench
========================================

// Module: equiv_check_sequencer
// PURPOSE
//   On-chip equivalence-check controller for a golden model and its post-route netlist.
//   Both are fed the same stimulus. Per run it:
//   - holds both in reset;
//   - drives NUM_VECTORS pseudo-random 32-bit vectors from an LFSR;
//   - waits a fixed settle time per vector, compares golden_out vs netlist_out, counts mismatches.
//   Sits between the two DUT instances and a status/host register block.
// PARAMETERS
//   DATA_W        32            stimulus/response width; elaboration error if != 32
//   NUM_VECTORS   1000          random vectors per run; 0 = reset compare only
//   RESET_CYCLES  2             cycles dut_rst held high per run; must be >= 1
//   SETTLE_CYCLES 2             cycles from stim launch to compare; must be >= 1
//   LFSR_SEED     32'hACE12468  first vector; 0 replaced by 32'h1
//   CNT_W         16            width of vec_cnt and mismatch_cnt
// PORTS
//   clk            in   1       single clock, rising edge
//   rst            in   1       asynchronous, active-low reset
//   start          in   1       1-cycle pulse; ignored while busy
//   dut_rst        out  1       active-high reset to both DUT instances
//   stim           out  DATA_W  stimulus to both DUTs, registered
//   golden_out     in   DATA_W  golden model response
//   netlist_out    in   DATA_W  post-route netlist response
//   busy           out  1       run in progress
//   done           out  1       level; run complete, held until next start
//   pass           out  1       valid when done: mismatch_cnt == 0
//   vec_cnt        out  CNT_W   vectors compared this run (reset compare excluded)
//   mismatch_cnt   out  CNT_W   mismatches this run, saturating at all-ones
// BEHAVIOUR
// - Reset (rst=0), applied immediately:
//   - state=IDLE, lfsr=seed;
//   - dut_rst=1, stim=0, busy=0, done=0, pass=0, counters=0.
//   - Reset mid-run aborts the run with the same values; no partial status is kept.
// - FSM states: IDLE -> RESET -> RUN -> DONE -> (start) RESET.
// - IDLE/DONE + start at edge E0:
//   - state=RESET, busy=1, done=0, pass=0;
//   - counters=0, lfsr=seed, stim=0, dut_rst=1.
// - RESET: dut_rst=1, stim=0 for RESET_CYCLES cycles. At edge E0+RESET_CYCLES:
//   - reset compare: a mismatch increments mismatch_cnt, not vec_cnt;
//   - dut_rst<=0, stim<=lfsr, lfsr advances, wait<=SETTLE_CYCLES-1;
//   - go to RUN. If NUM_VECTORS==0, go to DONE instead; dut_rst stays 1 and stim stays 0.
// - RUN: on each edge, if wait!=0 then decrement. Else (compare edge):
//   - compare, vec_cnt++;
//   - if vec_cnt reaches NUM_VECTORS: DONE;
//   - else stim<=lfsr, lfsr advances, wait reloads.
//   - Compare happens exactly SETTLE_CYCLES edges after stim changed.
//   - Mismatch and next launch happen on the same edge.
// - DONE: busy=0, done=1, pass=(mismatch_cnt==0); stim holds its last value; dut_rst=0.
//   - done rises at edge E0 + RESET_CYCLES + NUM_VECTORS*SETTLE_CYCLES.
// - Compare is a full-width bitwise inequality.
// - mismatch_cnt never wraps. vec_cnt width must hold NUM_VECTORS (elaboration check).
// - LFSR: 32-bit Galois, taps 32'h80200003 (x^32+x^22+x^2+x+1), shift right.
//   - Step: lsb=lfsr[0]; lfsr=(lfsr>>1) ^ (lsb ? TAPS : 0).
// - start in RESET/RUN is ignored. start in DONE restarts a run.
// CONFIGURATION
//   EQCHK_FIRST_FAIL_CAPTURE_EN
//   - Defined: adds outputs first_fail_valid (1), first_fail_idx (CNT_W),
//     first_fail_golden and first_fail_netlist (DATA_W).
//     - Latched on the first mismatch of a run; later mismatches do not update them.
//     - Reset compare index = all-ones; vector k (0-based) index = k.
//     - Cleared by reset and by start.
//   - Undefined: those ports and registers are absent; all other behaviour is identical.
// STRUCTURE
// - Package equiv_check_pkg: state enum (IDLE, RESET, RUN, DONE), LFSR_TAPS constant,
//   lfsr_next() function.
// - One sub-module, eqchk_lfsr: load/advance ports, seed parameter.
// - The FSM, counters and compare stay in this module.
// TESTING
// 1. netlist_out tied to golden_out, NUM_VECTORS=4, RESET_CYCLES=2, SETTLE_CYCLES=2, start pulse
//    -> done rises 10 edges after the start edge; pass=1, vec_cnt=4, mismatch_cnt=0.
// 2. Stim sequence check -> first stim = 32'hACE12468; second = lfsr_next(32'hACE12468);
//    stim is stable for 2 cycles per vector.
// 3. netlist_out = golden_out ^ 32'h1 only while vector 2 is applied
//    -> mismatch_cnt=1, pass=0; with the macro: first_fail_idx=2 and golden/netlist captured.
// 4. rst driven low in RUN at vector 1 -> immediately dut_rst=1, busy=0, stim=0,
//    counters=0; after release, start gives a clean full run.
// 5. start pulsed during RUN -> ignored; start in DONE -> counters cleared, new run,
//    stim sequence restarts at the seed.
// 6. CNT_W=4, NUM_VECTORS=10, constant mismatch (incl. reset compare) -> mismatch_cnt=11,
//    vec_cnt=10. Repeat with NUM_VECTORS=15 -> mismatch_cnt=15 saturated, no wrap.

Source files
------------

// File: rtl/equiv_check_pkg.sv
// Shared FSM state type and LFSR step function for the equivalence-check sequencer.
package equiv_check_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RESET = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } eqchk_state_t;

  // x^32 + x^22 + x^2 + x + 1, Galois form, shifting right
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/eqchk_lfsr.sv
// 32-bit Galois LFSR holding the next stimulus vector; load restarts at the seed.
module eqchk_lfsr
  import equiv_check_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [31:0] value
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [31:0] START = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

  // Sequence register: seed on reset/load, one step per advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= START;
    end else if (load) begin
      value <= START;
    end else if (advance) begin
      value <= lfsr_next(value);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/equiv_check_sequencer.sv
// Equivalence-check controller: resets both DUTs, drives LFSR vectors, counts response mismatches.
// Optional first-mismatch capture ports are added when EQCHK_FIRST_FAIL_CAPTURE_EN is defined.
module equiv_check_sequencer
  import equiv_check_pkg::*;
#(
  parameter int          DATA_W        = 32,
  parameter int          NUM_VECTORS   = 1000,
  parameter int          RESET_CYCLES  = 2,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468,
  parameter int          CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              dut_rst,
  output logic [DATA_W-1:0] stim,
  input  logic [DATA_W-1:0] golden_out,
  input  logic [DATA_W-1:0] netlist_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
  ,
  output logic              first_fail_valid,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_golden,
  output logic [DATA_W-1:0] first_fail_netlist
`endif
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("equiv_check_sequencer: DATA_W must be 32");
  end
  if (RESET_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("equiv_check_sequencer: RESET_CYCLES and SETTLE_CYCLES must be >= 1");
  end
  if (NUM_VECTORS < 0 || longint'(NUM_VECTORS) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_cnt_w
    $error("equiv_check_sequencer: CNT_W cannot hold NUM_VECTORS");
  end

  localparam int WAIT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int WAIT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] RESET_LOAD  = WAIT_W'(RESET_CYCLES - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LAST_VEC    = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);

  eqchk_state_t      state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       lfsr_value;
  logic              start_run, launch, compare, count_vec, finish;
  logic              mismatch;
  logic [CNT_W-1:0]  mismatch_cnt_next;

  eqchk_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start_run),
    .advance (launch),
    .value   (lfsr_value)
  );

  assign mismatch = (golden_out != netlist_out);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the per-edge strobes that steer the datapath.
  always_comb begin
    next_state = state;
    start_run  = 1'b0;
    launch     = 1'b0;
    compare    = 1'b0;
    count_vec  = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          next_state = RESET;
          start_run  = 1'b1;
        end else begin
          next_state = state;
        end
      end
      RESET: begin
        if (wait_cnt == '0) begin
          compare = 1'b1;
          if (NUM_VECTORS == 0) begin
            next_state = DONE;
            finish     = 1'b1;
          end else begin
            next_state = RUN;
            launch     = 1'b1;
          end
        end else begin
          next_state = state;
        end
      end
      RUN: begin
        if (wait_cnt == '0) begin
          compare   = 1'b1;
          count_vec = 1'b1;
          if (vec_cnt == LAST_VEC) begin
            next_state = DONE;
            finish     = 1'b1;
          end else begin
            launch = 1'b1;
          end
        end else begin
          next_state = state;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Saturating mismatch count including this edge's compare.
  always_comb begin
    mismatch_cnt_next = mismatch_cnt;
    if (compare && mismatch && !(&mismatch_cnt)) begin
      mismatch_cnt_next = mismatch_cnt + CNT_ONE;
    end else begin
      mismatch_cnt_next = mismatch_cnt;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dut_rst      <= 1'b1;
      stim         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      vec_cnt      <= '0;
      mismatch_cnt <= '0;
      wait_cnt     <= '0;
    end else if (start_run) begin
      dut_rst      <= 1'b1;
      stim         <= '0;
      busy         <= 1'b1;
      done         <= 1'b0;
      pass         <= 1'b0;
      vec_cnt      <= '0;
      mismatch_cnt <= '0;
      wait_cnt     <= RESET_LOAD;
    end else begin
      mismatch_cnt <= mismatch_cnt_next;
      if (count_vec) begin
        vec_cnt <= vec_cnt + CNT_ONE;
      end
      if (launch) begin
        dut_rst  <= 1'b0;
        stim     <= lfsr_value;
        wait_cnt <= SETTLE_LOAD;
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WAIT_W'(1);
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (mismatch_cnt_next == '0);
      end
    end
  end

`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
  // First mismatch of the run; the reset compare is reported as index all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_fail_valid   <= 1'b0;
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else if (start_run) begin
      first_fail_valid   <= 1'b0;
      first_fail_idx     <= '0;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else if (compare && mismatch && !first_fail_valid) begin
      first_fail_valid   <= 1'b1;
      first_fail_idx     <= (state == RESET) ? '1 : vec_cnt;
      first_fail_golden  <= golden_out;
      first_fail_netlist <= netlist_out;
    end
  end
`endif

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// Scoreboard bench: runs are predicted from the spec rules, a monitor checks stim launches and done.
module tb_equiv_check_sequencer;

  localparam int          NV   = 4;
  localparam int          RC   = 2;
  localparam int          SC   = 2;
  localparam int          CW   = 16;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic start_s = 1'b0;
  always #5 clk = ~clk;

  logic          dut_rst, busy, done, pass;
  logic [31:0]   stim, golden_out, netlist_out;
  logic [CW-1:0] vec_cnt, mismatch_cnt;
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
  logic          ff_valid;
  logic [CW-1:0] ff_idx;
  logic [31:0]   ff_golden, ff_netlist;
`endif

  equiv_check_sequencer #(.DATA_W(32), .NUM_VECTORS(NV), .RESET_CYCLES(RC),
                          .SETTLE_CYCLES(SC), .LFSR_SEED(SEED), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dut_rst(dut_rst), .stim(stim),
    .golden_out(golden_out), .netlist_out(netlist_out), .busy(busy), .done(done),
    .pass(pass), .vec_cnt(vec_cnt), .mismatch_cnt(mismatch_cnt)
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(ff_valid), .first_fail_idx(ff_idx),
    .first_fail_golden(ff_golden), .first_fail_netlist(ff_netlist)
`endif
  );

  // Two small-counter instances with a permanently mismatching netlist.
  logic        b_dut_rst, b_busy, b_done, b_pass, c_dut_rst, c_busy, c_done, c_pass;
  logic [31:0] b_stim, c_stim;
  logic [3:0]  b_vec, b_mis, c_vec, c_mis;
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
  logic        b_ffv, c_ffv;
  logic [3:0]  b_ffi, c_ffi;
  logic [31:0] b_ffg, b_ffn, c_ffg, c_ffn;
`endif

  equiv_check_sequencer #(.DATA_W(32), .NUM_VECTORS(10), .RESET_CYCLES(RC),
                          .SETTLE_CYCLES(SC), .LFSR_SEED(SEED), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_s), .dut_rst(b_dut_rst), .stim(b_stim),
    .golden_out(32'h0000_0000), .netlist_out(32'hFFFF_FFFF), .busy(b_busy), .done(b_done),
    .pass(b_pass), .vec_cnt(b_vec), .mismatch_cnt(b_mis)
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(b_ffv), .first_fail_idx(b_ffi),
    .first_fail_golden(b_ffg), .first_fail_netlist(b_ffn)
`endif
  );

  equiv_check_sequencer #(.DATA_W(32), .NUM_VECTORS(15), .RESET_CYCLES(RC),
                          .SETTLE_CYCLES(SC), .LFSR_SEED(SEED), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .start(start_s), .dut_rst(c_dut_rst), .stim(c_stim),
    .golden_out(32'h0000_0000), .netlist_out(32'hFFFF_FFFF), .busy(c_busy), .done(c_done),
    .pass(c_pass), .vec_cnt(c_vec), .mismatch_cnt(c_mis)
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
    , .first_fail_valid(c_ffv), .first_fail_idx(c_ffi),
    .first_fail_golden(c_ffg), .first_fail_netlist(c_ffn)
`endif
  );

  int passed = 0;
  int total = 0;
  int cyc = 0;
  int run_c0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the LFSR rule and a stand-in golden response function.
  function automatic logic [31:0] step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  function automatic logic [31:0] resp(input logic [31:0] s);
    return {s[15:0], s[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  logic [31:0] exp_vec [NV];
  logic [31:0] err_mask [NV];
  logic [31:0] rst_mask;
  logic [31:0] cur_mask;

  // Environment: both models held in reset give 0; the netlist deviates by the mask chosen per vector.
  always_comb begin
    cur_mask = 32'h0;
    for (int k = 0; k < NV; k++)
      if (exp_vec[k] == stim) cur_mask = err_mask[k];
    golden_out  = dut_rst ? 32'h0 : resp(stim);
    netlist_out = golden_out ^ (dut_rst ? rst_mask : cur_mask);
  end

  typedef struct { int cyc; logic [31:0] val; } stim_ev_t;
  typedef struct {
    int cyc; logic [CW-1:0] vc; logic [CW-1:0] mc; logic p;
    logic ffv; logic [CW-1:0] ffi; logic [31:0] ffg; logic [31:0] ffn;
  } res_t;
  stim_ev_t stim_q[$];
  res_t     res_q[$];

  task automatic push_expect(input int nvec, input bit with_result);
    res_t r;
    int   mc;
    for (int k = 0; k < nvec; k++) stim_q.push_back('{RC + k * SC, exp_vec[k]});
    if (with_result) begin
      mc = (rst_mask != 0) ? 1 : 0;
      r.ffv = 1'b0; r.ffi = '0; r.ffg = '0; r.ffn = '0;
      if (rst_mask != 0) begin
        r.ffv = 1'b1; r.ffi = '1; r.ffg = 32'h0; r.ffn = rst_mask;
      end
      for (int k = 0; k < NV; k++) begin
        if (err_mask[k] != 0) begin
          mc++;
          if (!r.ffv) begin
            r.ffv = 1'b1; r.ffi = CW'(k); r.ffg = resp(exp_vec[k]); r.ffn = r.ffg ^ err_mask[k];
          end
        end
      end
      if (mc > (1 << CW) - 1) mc = (1 << CW) - 1;
      r.cyc = RC + NV * SC; r.vc = CW'(NV); r.mc = CW'(mc); r.p = (mc == 0);
      res_q.push_back(r);
    end
  endtask

  task automatic clear_masks();
    rst_mask = 32'h0;
    for (int k = 0; k < NV; k++) err_mask[k] = 32'h0;
  endtask

  task automatic random_masks();
    rst_mask = ($urandom_range(3) == 0) ? ($urandom | 32'h1) : 32'h0;
    for (int k = 0; k < NV; k++) err_mask[k] = ($urandom_range(2) == 0) ? ($urandom | 32'h1) : 32'h0;
  endtask

  task automatic issue_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    run_c0 = cyc;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 0);
    chk("start_vec_cnt", vec_cnt, 0);
    chk("start_mismatch_cnt", mismatch_cnt, 0);
    chk("start_dut_rst", dut_rst, 1);
    chk("start_stim", stim, 0);
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
    chk("start_ff_valid", ff_valid, 0);
`endif
  endtask

  task automatic do_run(input bit mid_start);
    int c;
    push_expect(NV, 1'b1);
    issue_start();
    if (mid_start) begin
      repeat (RC + SC + 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("done_within_bound", done, 1);
    @(negedge clk);
  endtask

  // Monitor: pops an expectation on every vector launch and on every rising done.
  initial begin
    logic [31:0] ps;
    logic        pd;
    res_t        r;
    stim_ev_t    ev;
    ps = 32'h0;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && !dut_rst && stim !== ps) begin
        if (stim_q.size() == 0) begin
          total++;
          $display("FAIL stim_unexpected: got %0h expected no launch", stim);
        end else begin
          ev = stim_q.pop_front();
          chk("stim_value", stim, ev.val);
          chk("stim_cycle", cyc - run_c0, ev.cyc);
        end
      end
      if (rst && done && !pd) begin
        if (res_q.size() == 0) begin
          total++;
          $display("FAIL done_unexpected: got done=1 expected no completion");
        end else begin
          r = res_q.pop_front();
          chk("done_cycle", cyc - run_c0, r.cyc);
          chk("vec_cnt", vec_cnt, r.vc);
          chk("mismatch_cnt", mismatch_cnt, r.mc);
          chk("pass", pass, r.p);
          chk("done_busy", busy, 0);
          chk("done_dut_rst", dut_rst, 0);
          chk("done_stim_hold", stim, exp_vec[NV-1]);
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
          chk("ff_valid", ff_valid, r.ffv);
          if (r.ffv) begin
            chk("ff_idx", ff_idx, r.ffi);
            chk("ff_golden", ff_golden, r.ffg);
            chk("ff_netlist", ff_netlist, r.ffn);
          end
`endif
        end
      end
      ps = stim;
      pd = done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          c;
    exp_vec[0] = SEED;
    for (int k = 1; k < NV; k++) exp_vec[k] = step(exp_vec[k-1]);
    clear_masks();

    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_stim", stim, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_vec_cnt", vec_cnt, 0);
    chk("rst_mismatch_cnt", mismatch_cnt, 0);
    @(negedge clk) rst = 1'b1;

    // Clean run, then a single flipped bit on vector 2.
    do_run(1'b0);
    clear_masks();
    err_mask[2] = 32'h0000_0001;
    do_run(1'b0);

    // start while running is ignored.
    random_masks();
    do_run(1'b1);

    // Reset while vector 1 is applied aborts the run.
    clear_masks();
    push_expect(2, 1'b0);
    issue_start();
    repeat (RC + SC + 1) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_dut_rst", dut_rst, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_stim", stim, 0);
    chk("abort_vec_cnt", vec_cnt, 0);
    chk("abort_mismatch_cnt", mismatch_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("abort_launches_seen", stim_q.size(), 0);
    do_run(1'b0);

    repeat (4) begin
      random_masks();
      do_run(1'($urandom_range(1)));
    end

    // Small counters with every compare failing, including the reset compare.
    @(negedge clk) start_s = 1'b1;
    @(negedge clk) start_s = 1'b0;
    c = 0;
    while (!(b_done && c_done) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("sat_done", {b_done, c_done}, 2'b11);
    chk("b_vec_cnt", b_vec, 10);
    chk("b_mismatch_cnt", b_mis, 11);
    chk("b_pass", b_pass, 0);
    chk("c_vec_cnt", c_vec, 15);
    chk("c_mismatch_cnt", c_mis, 15);
    chk("c_pass", c_pass, 0);
    chk("sat_busy", {b_busy, c_busy}, 2'b00);
    chk("sat_dut_rst", {b_dut_rst, c_dut_rst}, 2'b00);
    v = SEED;
    repeat (9) v = step(v);
    chk("b_last_stim", b_stim, v);
    repeat (5) v = step(v);
    chk("c_last_stim", c_stim, v);
`ifdef EQCHK_FIRST_FAIL_CAPTURE_EN
    chk("b_ff_idx", {b_ffv, b_ffi, b_ffg, b_ffn}, {1'b1, 4'hF, 32'h0, 32'hFFFF_FFFF});
    chk("c_ff_idx", {c_ffv, c_ffi}, {1'b1, 4'hF});
    chk("c_ff_data", {c_ffg, c_ffn}, {32'h0, 32'hFFFF_FFFF});
`endif

    chk("stim_queue_drained", stim_q.size(), 0);
    chk("result_queue_drained", res_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
